sdram_req_arbiter: RTL and testbench
====================================

// Module: sdram_req_arbiter
// PURPOSE
//  Shares the single sdram_ctrl between the camera write path (8-word bursts from the width adapter)
//  and the VGA line-prefetch read path (burst addresses from the read-request FIFO). Grants one
//  request at a time, alternates fairly, lets an urgent read pre-empt, and throttles in-flight reads
//  with a credit counter so returning data cannot overrun the read-data FIFO.
// PARAMETERS
//  p_dram_burst_size  8    words per burst; power of 2
//  p_dram_dataw       16   SDRAM word width
//  p_req_addrw        24   request address width {bank,col,row}
//  p_max_streak       4    max consecutive grants to one side while the other waits
//  p_rd_credits       64   max read bursts outstanding in sdram_ctrl
// PORTS
//  i_clk            in   1                      single clock for the whole block (DRAM clock)
//  i_rst_n          in   1                      synchronous active-low reset
//  i_wr_valid       in   1                      write burst request from the width adapter
//  i_wr_addr        in   p_req_addrw            write burst address
//  i_wr_data        in   [burst] x p_dram_dataw write burst data array
//  o_wr_ready       out  1                      write request captured this cycle
//  i_rd_valid       in   1                      read burst request from the read-request FIFO
//  i_rd_addr        in   p_req_addrw            read burst address
//  o_rd_ready       out  1                      read request captured this cycle
//  i_rd_urgent      in   1                      read-data FIFO below low watermark; read pre-empts
//  i_rd_beat        in   1                      one read word returned (sdram_ctrl o_rd_valid)
//  o_ctrl_wr_valid  out  1                      to sdram_ctrl i_wr_req
//  o_ctrl_wr_addr   out  p_req_addrw            held while o_ctrl_wr_valid is high
//  o_ctrl_wr_data   out  [burst] x p_dram_dataw held while o_ctrl_wr_valid is high
//  i_ctrl_wr_ready  in   1                      sdram_ctrl o_wr_ready
//  o_ctrl_rd_valid  out  1                      to sdram_ctrl i_rd_req
//  o_ctrl_rd_addr   out  p_req_addrw            held while o_ctrl_rd_valid is high
//  i_ctrl_rd_ready  in   1                      sdram_ctrl o_rd_ready
//  o_rd_inflight    out  $clog2(p_rd_credits)+1 read bursts outstanding
//  o_err            out  1                      sticky: beat returned with zero bursts outstanding
// BEHAVIOUR
//  Reset (i_rst_n=0 at an edge): state=IDLE; all valids, readies and o_err at 0; o_rd_inflight=0;
//   streak, last-winner (=RD) and beat counter at 0. Reset mid-grant drops the held request.
//  FSM IDLE -> GRANT_WR | GRANT_RD -> IDLE.
//  IDLE decision, evaluated in order (rd_ok = i_rd_valid & inflight<p_rd_credits):
//   1) rd_ok & i_rd_urgent -> RD;
//   2) rd_ok & i_wr_valid -> the side not at streak limit; if neither is at the limit, the side
//      opposite last-winner;
//   3) else whichever single side is valid and eligible.
//  On a decision, o_wr_ready/o_rd_ready pulses 1 cycle (combinational in IDLE), and addr/data are
//   registered into the output holding regs. The next cycle enters GRANT_x with o_ctrl_x_valid=1.
//   Latency: upstream accept at N -> ctrl valid at N+1.
//  GRANT_x: valid and payload stay stable until i_ctrl_x_ready=1, then IDLE next cycle. Only one
//   ctrl valid is ever high. Minimum spacing is 2 cycles per request.
//  Streak: same winner as last -> streak+1 (saturating at p_max_streak); else streak=1.
//   Urgent reads ignore the streak limit (write starvation under constant urgency is accepted).
//  Inflight: +1 on read capture. A beat counter mod p_dram_burst_size gives -1 at each burst's last
//   beat. Both in one cycle: net 0. A beat when inflight=0 sets o_err and leaves inflight at 0.
//  Upstream valids may drop without a ready (FIFO sources); the decision samples them each IDLE cycle.
// STRUCTURE
//  Package sdram_arb_pkg: enum t_arb_state {IDLE,GRANT_WR,GRANT_RD}; struct t_wr_req {addr,data[]};
//   localparam c_beatw = $clog2(p_dram_burst_size).
//  Sub-module sdram_rd_credit: beat counter, inflight counter, o_err.
//  Top level: FSM, priority logic, holding regs.
// TESTING
//  Only wr valid, ctrl ready tied 1 -> o_wr_ready at cycle N, o_ctrl_wr_valid at N+1..N+1, ctrl
//   addr equals captured addr.
//  Both valid continuously, ready 1, no urgent -> grant order WR,RD,WR,RD...; never both valids high.
//  p_max_streak=4, wr valid always, rd valid from cycle 20 -> at most 4 WR after rd asserts before RD.
//  Hold i_ctrl_rd_ready=0 for 10 cycles -> addr stable, valid high throughout, no new upstream accept.
//  64 reads accepted, no beats -> o_rd_ready stays 0, o_rd_inflight=64; then 8 beats -> inflight=63,
//   next read granted.
//  i_rd_urgent=1 with streak RD at 4 and wr valid -> RD still wins; 1 beat at inflight=0 -> o_err=1;
//   i_rd_n=0 mid-GRANT_WR -> all valids 0 next cycle.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// ============================================================================
// Module : sdram_arb_pkg
// Brief  : Shared types and default sizes for the SDRAM request arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sdram_arb_pkg;

  localparam int c_dram_burst_size = 8;
  localparam int c_dram_dataw      = 16;
  localparam int c_req_addrw       = 24;
  localparam int c_beatw           = $clog2(c_dram_burst_size);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_WR = 2'd1,
    GRANT_RD = 2'd2
  } t_arb_state;

  typedef enum logic {
    SIDE_WR = 1'b0,
    SIDE_RD = 1'b1
  } t_side;

  typedef struct packed {
    logic [c_req_addrw-1:0]                           addr;
    logic [c_dram_burst_size-1:0][c_dram_dataw-1:0] data;
  } t_wr_req;

endpackage

`default_nettype wire

// File: rtl/sdram_rd_credit.sv
// ============================================================================
// Module : sdram_rd_credit
// Brief  : Counts read bursts outstanding in the SDRAM controller and flags
//          beats that arrive with nothing outstanding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_rd_credit
  import sdram_arb_pkg::*;
#(
  parameter int p_dram_burst_size = c_dram_burst_size,
  parameter int p_rd_credits      = 64,
  parameter int p_beatw           = c_beatw
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_rd_capture,
  input  logic                            i_rd_beat,
  output logic [$clog2(p_rd_credits):0]   o_rd_inflight,
  output logic                            o_err
);

  localparam int c_infw = $clog2(p_rd_credits) + 1;

  logic [p_beatw-1:0] r_beat_cnt;
  logic [c_infw-1:0]  r_inflight;
  logic               r_err;
  logic               w_none_out;
  logic               w_beat_ok;
  logic               w_burst_done;

  always_comb begin
    w_none_out   = (r_inflight == '0);
    w_beat_ok    = i_rd_beat && !w_none_out;
    w_burst_done = w_beat_ok && (r_beat_cnt == p_beatw'(p_dram_burst_size - 1));
  end

  // Orphan beats are not counted so the burst boundary stays aligned to real data.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_beat_cnt <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_beat_ok) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (i_rd_beat && w_none_out) begin
        r_err <= 1'b1;
      end
      case ({i_rd_capture, w_burst_done})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign o_rd_inflight = r_inflight;
  assign o_err         = r_err;

endmodule

`default_nettype wire

// File: rtl/sdram_req_arbiter.sv
// ============================================================================
// Module : sdram_req_arbiter
// Brief  : Fair write/read burst arbiter in front of sdram_ctrl with urgent
//          read pre-emption and read-credit throttling.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_req_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int p_dram_burst_size = c_dram_burst_size,
  parameter int p_dram_dataw      = c_dram_dataw,
  parameter int p_req_addrw       = c_req_addrw,
  parameter int p_max_streak      = 4,
  parameter int p_rd_credits      = 64
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst_n,
  input  logic                                          i_wr_valid,
  input  logic [p_req_addrw-1:0]                        i_wr_addr,
  input  logic [p_dram_burst_size-1:0][p_dram_dataw-1:0] i_wr_data,
  output logic                                          o_wr_ready,
  input  logic                                          i_rd_valid,
  input  logic [p_req_addrw-1:0]                        i_rd_addr,
  output logic                                          o_rd_ready,
  input  logic                                          i_rd_urgent,
  input  logic                                          i_rd_beat,
  output logic                                          o_ctrl_wr_valid,
  output logic [p_req_addrw-1:0]                        o_ctrl_wr_addr,
  output logic [p_dram_burst_size-1:0][p_dram_dataw-1:0] o_ctrl_wr_data,
  input  logic                                          i_ctrl_wr_ready,
  output logic                                          o_ctrl_rd_valid,
  output logic [p_req_addrw-1:0]                        o_ctrl_rd_addr,
  input  logic                                          i_ctrl_rd_ready,
  output logic [$clog2(p_rd_credits):0]                 o_rd_inflight,
  output logic                                          o_err
);

  localparam int                    c_infw       = $clog2(p_rd_credits) + 1;
  localparam int                    c_streakw    = $clog2(p_max_streak + 1);
  localparam logic [c_infw-1:0]     c_credits    = c_infw'(p_rd_credits);
  localparam logic [c_streakw-1:0]  c_streak_max = c_streakw'(p_max_streak);

  t_arb_state                                    r_state;
  t_side                                         r_last;
  logic [c_streakw-1:0]                          r_streak;
  logic [p_req_addrw-1:0]                        r_wr_addr;
  logic [p_dram_burst_size-1:0][p_dram_dataw-1:0] r_wr_data;
  logic [p_req_addrw-1:0]                        r_rd_addr;

  logic  w_rd_ok;
  logic  w_at_lim;
  logic  w_grant_wr;
  logic  w_grant_rd;
  t_side w_win;

  always_comb begin
    w_rd_ok    = i_rd_valid && (o_rd_inflight < c_credits);
    w_at_lim   = (r_streak >= c_streak_max);
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    if (i_rst_n && (r_state == IDLE)) begin
      if (w_rd_ok && i_rd_urgent) begin
        w_grant_rd = 1'b1;
      end else if (w_rd_ok && i_wr_valid) begin
        if (w_at_lim && (r_last == SIDE_RD)) begin
          w_grant_wr = 1'b1;
        end else if (w_at_lim && (r_last == SIDE_WR)) begin
          w_grant_rd = 1'b1;
        end else if (r_last == SIDE_RD) begin
          w_grant_wr = 1'b1;
        end else begin
          w_grant_rd = 1'b1;
        end
      end else if (i_wr_valid) begin
        w_grant_wr = 1'b1;
      end else if (w_rd_ok) begin
        w_grant_rd = 1'b1;
      end
    end
    w_win = w_grant_rd ? SIDE_RD : SIDE_WR;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_last    <= SIDE_RD;
      r_streak  <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_wr || w_grant_rd) begin
            r_last   <= w_win;
            r_streak <= (w_win != r_last) ? c_streakw'(1) :
                        (w_at_lim ? r_streak : r_streak + 1'b1);
          end
          if (w_grant_wr) begin
            r_state   <= GRANT_WR;
            r_wr_addr <= i_wr_addr;
            r_wr_data <= i_wr_data;
          end else if (w_grant_rd) begin
            r_state   <= GRANT_RD;
            r_rd_addr <= i_rd_addr;
          end
        end
        GRANT_WR: if (i_ctrl_wr_ready) r_state <= IDLE;
        GRANT_RD: if (i_ctrl_rd_ready) r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  assign o_wr_ready      = w_grant_wr;
  assign o_rd_ready      = w_grant_rd;
  assign o_ctrl_wr_valid = (r_state == GRANT_WR);
  assign o_ctrl_wr_addr  = r_wr_addr;
  assign o_ctrl_wr_data  = r_wr_data;
  assign o_ctrl_rd_valid = (r_state == GRANT_RD);
  assign o_ctrl_rd_addr  = r_rd_addr;

  sdram_rd_credit #(
    .p_dram_burst_size (p_dram_burst_size),
    .p_rd_credits      (p_rd_credits),
    .p_beatw           ($clog2(p_dram_burst_size))
  ) u_rd_credit (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_rd_capture  (w_grant_rd),
    .i_rd_beat     (i_rd_beat),
    .o_rd_inflight (o_rd_inflight),
    .o_err         (o_err)
  );

endmodule

`default_nettype wire

// File: tb/tb_sdram_req_arbiter.sv
// ============================================================================
// Module : tb_sdram_req_arbiter
// Brief  : Directed self-checking bench for sdram_req_arbiter with a
//          cycle-level reference model and per-scenario literal checks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sdram_req_arbiter;

  localparam int BURST = 8;
  localparam int DW    = 16;
  localparam int AW    = 24;
  localparam int MAXS  = 4;
  localparam int CRED  = 64;
  localparam int INFW  = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n;
  logic                     wr_valid;
  logic [AW-1:0]            wr_addr;
  logic [BURST-1:0][DW-1:0] wr_data;
  logic                     rd_valid;
  logic [AW-1:0]            rd_addr;
  logic                     rd_urgent;
  logic                     rd_beat;
  logic                     ctrl_wr_ready;
  logic                     ctrl_rd_ready;

  wire                      o_wr_ready;
  wire                      o_rd_ready;
  wire                      o_ctrl_wr_valid;
  wire [AW-1:0]             o_ctrl_wr_addr;
  wire [BURST-1:0][DW-1:0]  o_ctrl_wr_data;
  wire                      o_ctrl_rd_valid;
  wire [AW-1:0]             o_ctrl_rd_addr;
  wire [INFW-1:0]           o_rd_inflight;
  wire                      o_err;

  sdram_req_arbiter #(
    .p_dram_burst_size (BURST),
    .p_dram_dataw      (DW),
    .p_req_addrw       (AW),
    .p_max_streak      (MAXS),
    .p_rd_credits      (CRED)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_wr_valid      (wr_valid),
    .i_wr_addr       (wr_addr),
    .i_wr_data       (wr_data),
    .o_wr_ready      (o_wr_ready),
    .i_rd_valid      (rd_valid),
    .i_rd_addr       (rd_addr),
    .o_rd_ready      (o_rd_ready),
    .i_rd_urgent     (rd_urgent),
    .i_rd_beat       (rd_beat),
    .o_ctrl_wr_valid (o_ctrl_wr_valid),
    .o_ctrl_wr_addr  (o_ctrl_wr_addr),
    .o_ctrl_wr_data  (o_ctrl_wr_data),
    .i_ctrl_wr_ready (ctrl_wr_ready),
    .o_ctrl_rd_valid (o_ctrl_rd_valid),
    .o_ctrl_rd_addr  (o_ctrl_rd_addr),
    .i_ctrl_rd_ready (ctrl_rd_ready),
    .o_rd_inflight   (o_rd_inflight),
    .o_err           (o_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: side granted (0 none, 1 WR, 2 RD), bursts and beats as integers.
  int                       m_busy;
  logic [AW-1:0]            m_addr;
  logic [BURST-1:0][DW-1:0] m_data;
  int                       m_last;
  int                       m_streak;
  int                       m_inflight;
  int                       m_beats;
  bit                       m_err;

  function automatic int m_decide();
    bit rd_ok;
    rd_ok = rd_valid && (m_inflight < CRED);
    if (rd_ok && rd_urgent) return 2;
    // A side at its streak limit is always the last winner, so both rules pick the other side.
    if (rd_ok && wr_valid) return (m_last == 2) ? 1 : 2;
    if (wr_valid) return 1;
    if (rd_ok) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin : model_step
    int d;
    int inf_n;
    int beats_n;
    bit err_n;
    if (!rst_n) begin
      m_busy     <= 0;
      m_last     <= 2;
      m_streak   <= 0;
      m_inflight <= 0;
      m_beats    <= 0;
      m_err      <= 1'b0;
    end else begin
      d       = (m_busy == 0) ? m_decide() : 0;
      inf_n   = m_inflight;
      beats_n = m_beats;
      err_n   = m_err;
      if (m_busy == 1 && ctrl_wr_ready) m_busy <= 0;
      else if (m_busy == 2 && ctrl_rd_ready) m_busy <= 0;
      else if (d != 0) begin
        m_busy   <= d;
        m_addr   <= (d == 1) ? wr_addr : rd_addr;
        if (d == 1) m_data <= wr_data;
        m_streak <= (d == m_last) ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 1;
        m_last   <= d;
      end
      if (rd_beat) begin
        if (m_inflight == 0) err_n = 1'b1;
        else begin
          beats_n = (m_beats + 1) % BURST;
          if (beats_n == 0) inf_n = inf_n - 1;
        end
      end
      if (d == 2) inf_n = inf_n + 1;
      m_inflight <= inf_n;
      m_beats    <= beats_n;
      m_err      <= err_n;
    end
  end

  always @(negedge clk) begin : compare
    int d;
    if (chk_en) begin
      d = (rst_n && m_busy == 0) ? m_decide() : 0;
      chk("m_wr_ready", 128'(o_wr_ready), 128'(d == 1));
      chk("m_rd_ready", 128'(o_rd_ready), 128'(d == 2));
      chk("m_ctrl_wr_valid", 128'(o_ctrl_wr_valid), 128'(m_busy == 1));
      chk("m_ctrl_rd_valid", 128'(o_ctrl_rd_valid), 128'(m_busy == 2));
      chk("m_one_valid", 128'(o_ctrl_wr_valid && o_ctrl_rd_valid), 128'(0));
      if (m_busy == 1) begin
        chk("m_ctrl_wr_addr", 128'(o_ctrl_wr_addr), 128'(m_addr));
        chk("m_ctrl_wr_data", 128'(o_ctrl_wr_data), 128'(m_data));
      end
      if (m_busy == 2) chk("m_ctrl_rd_addr", 128'(o_ctrl_rd_addr), 128'(m_addr));
      chk("m_inflight", 128'(o_rd_inflight), 128'(m_inflight));
      chk("m_err", 128'(o_err), 128'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BURST-1:0][DW-1:0] mkdata(input logic [AW-1:0] a);
    logic [BURST-1:0][DW-1:0] v;
    for (int i = 0; i < BURST; i++) v[i] = DW'(a[15:0] * 3 + 16'(i));
    return v;
  endfunction

  task automatic do_reset();
    rst_n         = 1'b0;
    wr_valid      = 1'b0;
    rd_valid      = 1'b0;
    rd_urgent     = 1'b0;
    rd_beat       = 1'b0;
    ctrl_wr_ready = 1'b1;
    ctrl_rd_ready = 1'b1;
    wr_addr       = '0;
    wr_data       = '0;
    rd_addr       = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int q[$];
    int nwr;
    int nrd;
    bit got;
    bit alt;

    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_inflight", 128'(o_rd_inflight), 128'(0));
    chk("rst_err", 128'(o_err), 128'(0));
    chk("rst_valids", 128'({o_ctrl_wr_valid, o_ctrl_rd_valid}), 128'(0));

    // Single write, ready tied high: accept at N, ctrl valid exactly at N+1.
    tick();
    wr_addr  = 24'h123456;
    wr_data  = mkdata(24'h123456);
    wr_valid = 1'b1;
    @(negedge clk);
    chk("wr_accept", 128'(o_wr_ready), 128'(1));
    tick();
    wr_valid = 1'b0;
    wr_addr  = 24'h000000;
    @(negedge clk);
    chk("wr_ctrl_valid", 128'(o_ctrl_wr_valid), 128'(1));
    chk("wr_ctrl_addr", 128'(o_ctrl_wr_addr), 128'(24'h123456));
    tick();
    @(negedge clk);
    chk("wr_ctrl_done", 128'(o_ctrl_wr_valid), 128'(0));

    // Both valid continuously: grants alternate starting with WR after reset.
    do_reset();
    wr_valid = 1'b1;
    rd_valid = 1'b1;
    wr_addr  = 24'h010000;
    rd_addr  = 24'h020000;
    wr_data  = mkdata(wr_addr);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_wr_ready) q.push_back(1);
      if (o_rd_ready) q.push_back(2);
      tick();
      wr_addr = wr_addr + 24'd8;
      rd_addr = rd_addr + 24'd8;
      wr_data = mkdata(wr_addr);
    end
    chk("alt_count", 128'(q.size()), 128'(10));
    if (q.size() >= 4) chk("alt_first4", 128'({q[0][1:0], q[1][1:0], q[2][1:0], q[3][1:0]}), 128'(8'b01_10_01_10));
    alt = 1'b1;
    for (int i = 1; i < q.size(); i++) if (q[i] == q[i-1]) alt = 1'b0;
    chk("alt_order", 128'(alt), 128'(1));

    // Writes alone build a streak; a read arriving later must win within the limit.
    do_reset();
    wr_valid = 1'b1;
    wr_addr  = 24'h300000;
    wr_data  = mkdata(wr_addr);
    repeat (20) tick();
    rd_valid = 1'b1;
    rd_addr  = 24'h400000;
    nwr = 0;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (o_rd_ready) got = 1'b1;
      else if (o_wr_ready) nwr++;
      tick();
    end
    chk("streak_rd_granted", 128'(got), 128'(1));
    chk("streak_wr_le_max", 128'(nwr <= MAXS), 128'(1));

    // Controller stalls a read for 10 cycles: payload held, no new accepts.
    do_reset();
    ctrl_rd_ready = 1'b0;
    rd_valid      = 1'b1;
    rd_addr       = 24'hABCDEF;
    @(negedge clk);
    chk("stall_accept", 128'(o_rd_ready), 128'(1));
    tick();
    rd_addr  = 24'h111111;
    wr_valid = 1'b1;
    wr_addr  = 24'h222222;
    wr_data  = mkdata(wr_addr);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_hold", 128'({o_ctrl_rd_valid, o_ctrl_rd_addr, o_wr_ready, o_rd_ready}),
          128'({1'b1, 24'hABCDEF, 1'b0, 1'b0}));
      tick();
    end
    ctrl_rd_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("stall_release", 128'(o_ctrl_rd_valid), 128'(0));
    chk("stall_next_wr", 128'(o_wr_ready), 128'(1));
    tick();
    wr_valid = 1'b0;
    rd_valid = 1'b0;

    // Credit exhaustion: 64 reads outstanding block the 65th until one burst drains.
    do_reset();
    rd_valid = 1'b1;
    rd_addr  = 24'h500000;
    nrd = 0;
    for (int c = 0; c < 200 && nrd < CRED; c++) begin
      @(negedge clk);
      if (o_rd_ready) nrd++;
      tick();
      rd_addr = rd_addr + 24'd8;
    end
    chk("credit_accepts", 128'(nrd), 128'(CRED));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("credit_block", 128'(o_rd_ready), 128'(0));
      tick();
    end
    @(negedge clk);
    chk("credit_full", 128'(o_rd_inflight), 128'(64));
    tick();
    rd_beat = 1'b1;
    repeat (8) tick();
    rd_beat = 1'b0;
    @(negedge clk);
    chk("credit_drain", 128'(o_rd_inflight), 128'(63));
    chk("credit_regrant", 128'(o_rd_ready), 128'(1));
    tick();
    rd_valid = 1'b0;
    @(negedge clk);
    chk("credit_refill", 128'(o_rd_inflight), 128'(64));

    // Urgent read wins even with RD at its streak limit and a write waiting.
    do_reset();
    rd_valid = 1'b1;
    rd_addr  = 24'h600000;
    nrd = 0;
    for (int c = 0; c < 40 && nrd < 4; c++) begin
      @(negedge clk);
      if (o_rd_ready) nrd++;
      if (nrd < 4) tick();
    end
    chk("urgent_setup", 128'(nrd), 128'(4));
    tick();
    wr_valid  = 1'b1;
    wr_addr   = 24'h700000;
    wr_data   = mkdata(wr_addr);
    rd_urgent = 1'b1;
    tick();
    @(negedge clk);
    chk("urgent_rd_wins", 128'({o_rd_ready, o_wr_ready}), 128'(2'b10));
    tick();
    rd_urgent = 1'b0;
    rd_valid  = 1'b0;
    wr_valid  = 1'b0;

    // Orphan beat sets the sticky error and leaves inflight at zero.
    do_reset();
    rd_beat = 1'b1;
    tick();
    rd_beat = 1'b0;
    @(negedge clk);
    chk("err_set", 128'({o_err, o_rd_inflight}), 128'({1'b1, 7'd0}));
    tick();
    @(negedge clk);
    chk("err_sticky", 128'(o_err), 128'(1));

    // Reset during GRANT_WR drops the held request.
    do_reset();
    ctrl_wr_ready = 1'b0;
    wr_valid      = 1'b1;
    wr_addr       = 24'h0F0F0F;
    wr_data       = mkdata(wr_addr);
    @(negedge clk);
    chk("rstg_accept", 128'(o_wr_ready), 128'(1));
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("rstg_granted", 128'(o_ctrl_wr_valid), 128'(1));
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("rstg_dropped", 128'({o_ctrl_wr_valid, o_ctrl_rd_valid, o_wr_ready, o_rd_ready}), 128'(0));
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("rstg_stays_idle", 128'(o_ctrl_wr_valid), 128'(0));

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
